dbus_arbiter: RTL

//  Two-master arbiter for the word-aligned data bus (post-daligner side) feeding dmem and vram.

---
 rtl/dbus_arbiter_pkg.sv | 28 ++
 rtl/dbus_arbiter_rr_arb2.sv | 24 ++
 rtl/dbus_arbiter.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/dbus_arbiter_pkg.sv
// Shared types and constants for the two-master data-bus arbiter.
// Window match compares the top WIN_W bits of the byte address against the base.
package dbus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } dbus_st_e;

  localparam logic [3:0] WSTB_READ = 4'b0000;
  localparam int         WIN_W     = 12;
  localparam int         NUM_MST   = 2;

  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstb;
  } dbus_req_t;

  typedef struct packed {
    logic        ack;
    logic        err;
    logic [31:0] rdata;
  } dbus_rsp_t;

endpackage

// File: rtl/dbus_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: a lone requester wins, a tie goes to the master
// that did not win last. last_grant only moves when the caller accepts a grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic last_grant;  // 0 = master 0, 1 = master 1

  always_comb begin
    gnt[0] = req[0] & (~req[1] |  last_grant);
    gnt[1] = req[1] & (~req[0] | ~last_grant);
  end

  // Reset to master 1 so master 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                last_grant <= 1'b1;
    else if (advance && |req)  last_grant <= gnt[1];
  end

endmodule

// File: rtl/dbus_arbiter.sv
// Two-master arbiter for the word-aligned data bus: arbitrates, sequences one
// access at a time, decodes DMEM/VRAM chip enables and returns data with a 1-cycle ACK.
module dbus_arbiter
  import dbus_arbiter_pkg::*;
#(
  parameter logic [31:0] DMEM_BASE = 32'h0010_0000,
  parameter logic [31:0] VRAM_BASE = 32'h7ff0_0000,
  parameter int          RD_LAT    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic [29:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstb,
  output logic        m0_ack,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic [29:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstb,
  output logic        m1_ack,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic [29:0] maddr,
  output logic [31:0] mdatao,
  output logic [3:0]  mwstb,
  output logic        cem,
  output logic        cev,
  input  logic [31:0] mdatai_dmem,
  input  logic [31:0] mdatai_vram
);

  localparam int CNT_W = $clog2(RD_LAT + 1);

  localparam logic [WIN_W-1:0] DMEM_WIN = DMEM_BASE[31:32-WIN_W];
  localparam logic [WIN_W-1:0] VRAM_WIN = VRAM_BASE[31:32-WIN_W];

  dbus_req_t [NUM_MST-1:0] mreq;
  dbus_rsp_t [NUM_MST-1:0] rsp;
  logic      [NUM_MST-1:0] req;
  logic      [NUM_MST-1:0] gnt;

  dbus_st_e         state;
  logic             cur_mst;
  logic             is_rd;
  logic             hit_dmem;
  logic             hit_vram;
  logic [CNT_W-1:0] cnt;

  dbus_req_t        greq;
  logic [WIN_W-1:0] g_win;
  logic             g_dmem;
  logic             g_vram;
  logic             advance;
  logic             mapped;
  logic             rd_done;
  logic             rsp_go;
  logic [31:0]      rd_sel;

  assign req     = {m1_req, m0_req};
  assign mreq[0] = {m0_addr, m0_wdata, m0_wstb};
  assign mreq[1] = {m1_addr, m1_wdata, m1_wstb};

  assign advance = (state == ST_IDLE) && (|req);

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .advance (advance),
    .gnt     (gnt)
  );

  // Decode on the granted request so the window hit is registered with the grant.
  always_comb begin
    greq   = gnt[1] ? mreq[1] : mreq[0];
    g_win  = greq.addr[29:30-WIN_W];
    g_dmem = (g_win == DMEM_WIN);
    g_vram = (g_win == VRAM_WIN) && !g_dmem;
  end

  assign mapped  = hit_dmem | hit_vram;
  assign rd_done = (state == ST_WAIT) && (cnt == CNT_W'(1));
  assign rsp_go  = ((state == ST_ISSUE) && !(is_rd && mapped)) || rd_done;
  assign rd_sel  = hit_dmem ? mdatai_dmem : mdatai_vram;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cur_mst  <= 1'b0;
      is_rd    <= 1'b0;
      hit_dmem <= 1'b0;
      hit_vram <= 1'b0;
      cnt      <= '0;
      maddr    <= '0;
      mdatao   <= '0;
      mwstb    <= '0;
      cem      <= 1'b0;
      cev      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (advance) begin
            cur_mst  <= gnt[1];
            is_rd    <= (greq.wstb == WSTB_READ);
            hit_dmem <= g_dmem;
            hit_vram <= g_vram;
            maddr    <= greq.addr;
            mdatao   <= greq.wdata;
            mwstb    <= greq.wstb;
            cem      <= g_dmem;
            cev      <= g_vram;
            state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          cem <= 1'b0;
          cev <= 1'b0;
          if (is_rd && mapped) begin
            cnt   <= CNT_W'(RD_LAT);
            state <= ST_WAIT;
          end else begin
            state <= ST_RESP;
          end
        end
        ST_WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= ST_RESP;
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Per-master response: ACK/ERR are pulses, RDATA holds its last value between ACKs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp <= '0;
    end else begin
      for (int m = 0; m < NUM_MST; m++) begin
        rsp[m].ack <= rsp_go && (cur_mst == 1'(m));
        rsp[m].err <= rsp_go && (cur_mst == 1'(m)) && !mapped;
        if (rd_done && (cur_mst == 1'(m)))
          rsp[m].rdata <= rd_sel;
        else if (rsp_go && (cur_mst == 1'(m)))
          rsp[m].rdata <= '0;
      end
    end
  end

  assign m0_ack   = rsp[0].ack;
  assign m0_err   = rsp[0].err;
  assign m0_rdata = rsp[0].rdata;
  assign m1_ack   = rsp[1].ack;
  assign m1_err   = rsp[1].err;
  assign m1_rdata = rsp[1].rdata;

endmodule
